// File: rtl/mac_tdm.sv
// Pipelined signed multiply-accumulate with per-channel TDM accumulators.
// Stages: A2/B2 -> M -> P (accumulate) -> output; fixed four-edge latency.
module mac_tdm #(
  parameter int WIDTH_A   = 8,
  parameter int WIDTH_B   = 8,
  parameter int NUM_CH    = 4,
  parameter int ACC_WIDTH = WIDTH_A + WIDTH_B + 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [CH_W-1:0]      in_ch,
  input  logic                 in_mode,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [WIDTH_A-1:0]   din_a,
  input  logic [WIDTH_B-1:0]   din_b,
  output logic                 out_valid,
  output logic [CH_W-1:0]      out_ch,
  output logic [ACC_WIDTH-1:0] dout_p,
  output logic                 out_ovf
);

  localparam int MW = WIDTH_A + WIDTH_B;
  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

  logic                        s1_v;
  logic [CH_W-1:0]             s1_ch;
  logic                        s1_mode;
  logic                        s1_first;
  logic                        s1_last;
  logic signed [WIDTH_A-1:0]   s1_a;
  logic signed [WIDTH_B-1:0]   s1_b;

  logic                        s2_v;
  logic [CH_W-1:0]             s2_ch;
  logic                        s2_mode;
  logic                        s2_first;
  logic                        s2_last;
  logic signed [MW-1:0]        s2_m;

  logic                        p_v;
  logic [CH_W-1:0]             p_ch;
  logic                        p_ovf;
  logic signed [ACC_WIDTH-1:0] p_res;

  logic signed [ACC_WIDTH-1:0] acc [NUM_CH];
  logic                        ovf [NUM_CH];

  logic                        ch_ok;
  logic signed [ACC_WIDTH-1:0] acc_rd;
  logic                        ovf_rd;
  logic signed [ACC_WIDTH-1:0] m_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        sov;
  logic                        acc_we;
  logic signed [ACC_WIDTH-1:0] acc_nx;
  logic                        ovf_nx;
  logic                        emit;
  logic signed [ACC_WIDTH-1:0] res;
  logic                        rovf;

  assign ch_ok = ({1'b0, in_ch} < NCH);

  always_ff @(posedge clk) begin
    s1_a  <= din_a;
    s1_b  <= din_b;
    s2_m  <= MW'(s1_a) * MW'(s1_b);
    p_res <= res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_ch     <= '0;
      s1_mode   <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s2_v      <= 1'b0;
      s2_ch     <= '0;
      s2_mode   <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      p_v       <= 1'b0;
      p_ch      <= '0;
      p_ovf     <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      dout_p    <= '0;
      out_ovf   <= 1'b0;
    end else begin
      s1_v      <= in_valid && ch_ok;
      s1_ch     <= in_ch;
      s1_mode   <= in_mode;
      s1_first  <= in_first;
      s1_last   <= in_last;
      s2_v      <= s1_v;
      s2_ch     <= s1_ch;
      s2_mode   <= s1_mode;
      s2_first  <= s1_first;
      s2_last   <= s1_last;
      p_v       <= emit;
      p_ch      <= s2_ch;
      p_ovf     <= rovf;
      out_valid <= p_v;
      out_ch    <= p_ch;
      dout_p    <= p_res;
      out_ovf   <= p_ovf;
    end
  end

  // Same-cycle read of the value written at the previous edge: no bubbles.
  always_comb begin
    acc_rd = '0;
    ovf_rd = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s2_ch == CH_W'(i)) begin
        acc_rd = acc[i];
        ovf_rd = ovf[i];
      end
    end
  end

  assign m_ext = ACC_WIDTH'(s2_m);
  assign sum   = acc_rd + m_ext;
  assign sov   = (acc_rd[ACC_WIDTH-1] == m_ext[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != acc_rd[ACC_WIDTH-1]);

  always_comb begin
    acc_we = 1'b0;
    acc_nx = acc_rd;
    ovf_nx = ovf_rd;
    emit   = 1'b0;
    res    = m_ext;
    rovf   = 1'b0;
    unique case (1'b1)
      !s2_v: begin
      end
      s2_v && !s2_mode: begin
        emit = 1'b1;
      end
      s2_v && s2_mode && s2_first: begin
        acc_we = 1'b1;
        acc_nx = m_ext;
        ovf_nx = 1'b0;
        emit   = s2_last;
      end
      s2_v && s2_mode && !s2_first: begin
        acc_we = 1'b1;
        acc_nx = sum;
        ovf_nx = ovf_rd | sov;
        emit   = s2_last;
        res    = sum;
        rovf   = ovf_rd | sov;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        ovf[i] <= 1'b0;
      end
    end else if (acc_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (s2_ch == CH_W'(i)) begin
          acc[i] <= acc_nx;
          ovf[i] <= ovf_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_tdm.sv
// Scoreboard bench for mac_tdm: 8x8 operands, 16-bit accumulator,
// five channels so that in_ch=5 is representable and out of range.
module tb_mac_tdm;

  localparam int CH_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [CH_W-1:0]   in_ch = '0;
  logic              in_mode = 1'b0;
  logic              in_first = 1'b0;
  logic              in_last = 1'b0;
  logic [7:0]        din_a = '0;
  logic [7:0]        din_b = '0;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [15:0]       dout_p;
  logic              out_ovf;

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [15:0]     p;
    logic            ovf;
    int              at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  mac_tdm #(
    .WIDTH_A(8), .WIDTH_B(8), .NUM_CH(5), .ACC_WIDTH(16)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ch(in_ch), .in_mode(in_mode),
    .in_first(in_first), .in_last(in_last),
    .din_a(din_a), .din_b(din_b),
    .out_valid(out_valid), .out_ch(out_ch),
    .dout_p(dout_p), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic beat(input int ch, input bit mode, input bit first,
                      input bit last, input int a, input int b,
                      input bit exp, input int p, input bit ovf);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    in_mode  = mode;
    in_first = first;
    in_last  = last;
    din_a    = 8'(a);
    din_b    = 8'(b);
    if (exp) begin
      e.ch  = CH_W'(ch);
      e.p   = 16'(p);
      e.ovf = ovf;
      e.at  = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0",
               sb.size());
      sb.delete();
    end
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL unexpected_out: ch=%0d p=%0d, required none",
                       out_ch, $signed(dout_p));
            end else begin
              e = sb.pop_front();
              if (out_ch !== e.ch || dout_p !== e.p ||
                  out_ovf !== e.ovf || cyc != e.at + 3) begin
                errors++;
                $display({"FAIL result: ch=%0d p=%0d ovf=%0d edge=%0d, ",
                          "required ch=%0d p=%0d ovf=%0d edge=%0d"},
                         out_ch, $signed(dout_p), out_ovf, cyc,
                         e.ch, $signed(e.p), e.ovf, e.at + 3);
              end
            end
          end
        end
      end
      begin : stim
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_dout_p", int'(dout_p), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);

        beat(0, 0, 0, 0, -3, 7, 1, -21, 0);
        idle();
        drain();

        for (int i = 0; i < 4; i++)
          beat(1, 1, i == 0, i == 3, 10, 10 + i, i == 3, 460, 0);
        idle();
        drain();

        for (int i = 0; i < 4; i++) begin
          beat(0, 1, i == 0, i == 3, 1, 1 + i, i == 3, 10, 0);
          beat(1, 1, i == 0, i == 3, -2, 5 + i, i == 3, -52, 0);
        end
        idle();
        drain();

        for (int i = 0; i < 3; i++)
          beat(2, 1, i == 0, i == 2, 127, 127, i == 2, -17149, 1);
        beat(2, 1, 1, 0, 1, 1, 0, 0, 0);
        beat(2, 1, 0, 1, 1, 2, 1, 3, 0);
        beat(2, 0, 0, 0, 2, 2, 1, 4, 0);
        beat(2, 1, 0, 1, 1, 1, 1, 4, 0);
        idle();
        drain();

        beat(0, 1, 1, 1, 5, 5, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 5; c++)
          beat(c, 1, 0, 1, 0, 0, 1, 0, 0);
        idle();
        drain();

        beat(1, 1, 1, 1, 3, 3, 1, 9, 0);
        beat(5, 1, 0, 1, 9, 9, 0, 0, 0);
        beat(6, 0, 0, 0, 9, 9, 0, 0, 0);
        beat(1, 1, 0, 1, 0, 0, 1, 9, 0);
        beat(3, 1, 1, 1, -128, -128, 1, 16384, 0);
        idle();
        drain();
        repeat (6) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        done = 1'b1;
      end
      begin : watchdog
        repeat (2000) @(negedge clk);
        if (!done) begin
          $display("FAIL watchdog: stimulus not done, required done");
          $fatal(1, "watchdog expired");
        end
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
